// File: rtl/widen_arbiter.sv
// Four-requester round-robin arbiter feeding a single output register that
// sign-extends the granted LENGTH-bit operand to 20 bits.
module widen_arbiter #(
  parameter int LENGTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            cfg_mask,
  input  logic [3:0]            req_valid,
  input  logic [4*LENGTH-1:0]   req_data,
  output logic [3:0]            req_ready,
  output logic                  out_valid,
  output logic [19:0]           out_data,
  output logic [1:0]            out_src,
  input  logic                  out_ready,
  output logic [15:0]           xfer_count,
  output logic                  state_dbg
);

  // Handshake: a word moves on any side only in a cycle where both valid and
  // ready are 1 at the rising edge; valid never waits on ready, ready may
  // depend combinationally on valid.
  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

  state_t              state;
  logic [1:0]          last_grant;
  logic [3:0]          eligible;
  logic                slot_free;
  logic [3:0]          grant;
  logic [1:0]          grant_idx;
  logic [1:0]          cand;
  logic                found;
  logic [LENGTH-1:0]   sel_op;
  logic [19:0]         sel_ext;

  assign out_valid = (state == FULL);
  assign state_dbg = state;
  assign req_ready = grant;

  // Search starts one past the last winner; the k=4 step revisits last_grant
  // itself so it keeps the lowest priority.
  always_comb begin
    eligible  = req_valid & cfg_mask;
    slot_free = (state == IDLE) || out_ready;
    grant     = '0;
    grant_idx = last_grant;
    cand      = '0;
    found     = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!rst && slot_free && !found && eligible[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    sel_op               = req_data[int'(grant_idx)*LENGTH +: LENGTH];
    sel_ext              = {20{sel_op[LENGTH-1]}};
    sel_ext[LENGTH-1:0]  = sel_op;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_data   <= '0;
      out_src    <= '0;
      xfer_count <= '0;
      last_grant <= 2'd3;
    end else begin
      if (state == FULL && out_ready)
        xfer_count <= xfer_count + 16'd1;
      if (found) begin
        state      <= FULL;
        out_data   <= sel_ext;
        out_src    <= grant_idx;
        last_grant <= grant_idx;
      end else if (out_ready) begin
        state      <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_widen_arbiter.sv
// Directed bench for widen_arbiter at LENGTH=10: sign extension, round robin,
// backpressure, masking, reset mid-flight and counter wrap.
module tb_widen_arbiter;

  localparam int LENGTH = 10;

  logic                clk;
  logic                rst;
  logic [3:0]          cfg_mask;
  logic [3:0]          req_valid;
  logic [4*LENGTH-1:0] req_data;
  logic [3:0]          req_ready;
  logic                out_valid;
  logic [19:0]         out_data;
  logic [1:0]          out_src;
  logic                out_ready;
  logic [15:0]         xfer_count;
  logic                state_dbg;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];

  widen_arbiter #(.LENGTH(LENGTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_mask   (cfg_mask),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .xfer_count (xfer_count),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [LENGTH-1:0] v);
    req_data[idx*LENGTH +: LENGTH] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("ready_in_reset", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0;
  endtask

  task automatic check_out(input string tag);
    logic [19:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(out_data), 32'(e));
    end
  endtask

  logic [LENGTH-1:0] rr_data [4];
  logic [19:0]       rr_exp  [4];

  initial begin
    rst       = 1'b1;
    cfg_mask  = 4'hF;
    req_valid = 4'hF;
    req_data  = '0;
    out_ready = 1'b1;
    rr_data   = '{10'h005, 10'h2AA, 10'h155, 10'h3C0};
    rr_exp    = '{20'h00005, 20'hFFEAA, 20'h00155, 20'hFFFC0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("ready_in_reset", 32'(req_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_src", 32'(out_src), 32'h0);
    check("rst_xfer", 32'(xfer_count), 32'h0);
    check("rst_state", 32'(state_dbg), 32'h0);
    rst = 1'b0;

    // sign extension, back-to-back from requester 0
    req_valid = 4'b0001;
    set_data(0, 10'h3FF);
    exp_q.push_back(20'hFFFFF);
    exp_q.push_back(20'h001FF);
    exp_q.push_back(20'hFFE00);
    #1 check("sx_ready0", 32'(req_ready), 32'h1);
    tick();
    check("sx_valid0", 32'(out_valid), 32'h1);
    check_out("sx_data0");
    check("sx_src0", 32'(out_src), 32'h0);
    set_data(0, 10'h1FF);
    #1 check("sx_ready1", 32'(req_ready), 32'h1);
    tick();
    check_out("sx_data1");
    check("sx_xfer1", 32'(xfer_count), 32'd1);
    set_data(0, 10'h200);
    tick();
    check_out("sx_data2");
    check("sx_src2", 32'(out_src), 32'h0);
    req_valid = 4'b0000;
    #1 check("sx_ready_none", 32'(req_ready), 32'h0);
    tick();
    check("sx_idle", 32'(out_valid), 32'h0);
    check("sx_xfer3", 32'(xfer_count), 32'd3);

    // round robin from reset: 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 4; i++) set_data(i, rr_data[i]);
    req_valid = 4'hF;
    #1 check("rr_ready_first", 32'(req_ready), 32'h1);
    for (int n = 0; n < 5; n++) begin
      exp_q.push_back(rr_exp[n % 4]);
      tick();
      check("rr_valid", 32'(out_valid), 32'h1);
      check("rr_src", 32'(out_src), 32'(n % 4));
      check_out("rr_data");
      check("rr_ready_next", 32'(req_ready), 32'(4'b0001 << ((n + 1) % 4)));
    end
    check("rr_xfer", 32'(xfer_count), 32'd4);

    // backpressure: hold FFE00, req1 waits, then goes in the release cycle
    do_reset();
    req_valid = 4'b0001;
    set_data(0, 10'h200);
    tick();
    out_ready = 1'b0;
    req_valid = 4'b0010;
    set_data(1, 10'h0F0);
    for (int n = 0; n < 5; n++) begin
      #1 check("bp_ready", 32'(req_ready), 32'h0);
      tick();
      check("bp_data", 32'(out_data), 32'hFFE00);
      check("bp_src", 32'(out_src), 32'h0);
      check("bp_valid", 32'(out_valid), 32'h1);
    end
    check("bp_xfer_hold", 32'(xfer_count), 32'd0);
    out_ready = 1'b1;
    #1 check("bp_release_ready", 32'(req_ready), 32'b0010);
    tick();
    check("bp_new_data", 32'(out_data), 32'h000F0);
    check("bp_new_src", 32'(out_src), 32'd1);
    check("bp_xfer", 32'(xfer_count), 32'd1);

    // masking: only 1 and 3, alternating (last grant was 1)
    cfg_mask  = 4'b1010;
    req_valid = 4'hF;
    for (int n = 0; n < 4; n++) begin
      #1 check("mask_ready", 32'(req_ready), (n % 2 == 0) ? 32'b1000 : 32'b0010);
      check("mask_blocked", 32'(req_ready & 4'b0101), 32'h0);
      tick();
      check("mask_src", 32'(out_src), (n % 2 == 0) ? 32'd3 : 32'd1);
    end

    // mask drop while held must not lose the output
    cfg_mask  = 4'b0000;
    out_ready = 1'b0;
    tick();
    check("mask_hold_valid", 32'(out_valid), 32'h1);
    check("mask_hold_src", 32'(out_src), 32'd1);
    out_ready = 1'b1;
    #1 check("mask_none_ready", 32'(req_ready), 32'h0);
    tick();
    check("mask_drain_idle", 32'(out_valid), 32'h0);

    // reset mid-operation while FULL
    cfg_mask  = 4'hF;
    req_valid = 4'b0100;
    tick();
    check("mid_full", 32'(out_valid), 32'h1);
    req_valid = 4'hF;
    do_reset();
    check("mid_valid", 32'(out_valid), 32'h0);
    check("mid_xfer", 32'(xfer_count), 32'h0);
    #1 check("mid_first_grant", 32'(req_ready), 32'b0001);

    // counter wrap
    do_reset();
    req_valid = 4'b0001;
    repeat (65536) tick();
    check("wrap_ffff", 32'(xfer_count), 32'hFFFF);
    tick();
    check("wrap_zero", 32'(xfer_count), 32'h0);
    req_valid = 4'b0000;
    tick();
    check("wrap_after", 32'(xfer_count), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
